// File: rtl/pg_gen_stage.sv
// pg_gen_stage: registered propagate/generate pre-processing stage for the
// prefix adder. Computes P = A^B and G = A&B, folding the carry-in into
// bit 0's generate term. A two-entry skid buffer decouples in_ready from
// out_ready while keeping strict FIFO order.
module pg_gen_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] g,
   output logic             cin_o
);

   // Occupancy states of the two-entry buffer
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Packed vector layout: {p, g, cin}
   localparam int VW = 2 * WIDTH + 1;

   // Propagate/generate with the carry-in folded into bit 0's generate
   function automatic logic [VW-1:0] calc_pg(
      input logic [WIDTH-1:0] a_i,
      input logic [WIDTH-1:0] b_i,
      input logic             c_i
   );
      logic [WIDTH-1:0] p_v;
      logic [WIDTH-1:0] g_v;
      p_v    = a_i ^ b_i;
      g_v    = a_i & b_i;
      g_v[0] = g_v[0] | (p_v[0] & c_i);
      return {p_v, g_v, c_i};
   endfunction

   logic [1:0]    state_d;
   logic [1:0]    state_q;
   logic [VW-1:0] main_d;
   logic [VW-1:0] main_q;
   logic [VW-1:0] skid_d;
   logic [VW-1:0] skid_q;
   logic [VW-1:0] in_vec_s;
   logic          accept_s;
   logic          pop_s;

   // in_ready depends only on reset and occupancy, never on out_ready
   assign in_ready  = ~rst & (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept_s  = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;
   assign in_vec_s  = calc_pg(a, b, cin);

   // The main register always holds the oldest vector and drives the outputs
   assign p     = main_q[VW-1:WIDTH+1];
   assign g     = main_q[WIDTH:1];
   assign cin_o = main_q[0];

   // Next-state and data-movement logic for the skid buffer
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               state_d = ST_ONE;
               main_d  = in_vec_s;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && pop_s) begin
               state_d = ST_ONE;
               main_d  = in_vec_s;
            end else if (accept_s) begin
               state_d = ST_FULL;
               skid_d  = in_vec_s;
            end else if (pop_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a pop can move data
            if (pop_s) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            // Unused encoding: recover to empty and drop contents
            state_d = ST_EMPTY;
            main_d  = {VW{1'b0}};
            skid_d  = {VW{1'b0}};
         end
      endcase
   end

   // State and data registers with synchronous reset clearing all contents
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= {VW{1'b0}};
         skid_q  <= {VW{1'b0}};
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pg_gen_stage.sv
// Testbench for pg_gen_stage: a queue-based reference model checked on every
// cycle, plus directed vectors with hand-computed expected values.
module tb_pg_gen_stage;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] p;
   logic [W-1:0] g;
   logic         cin_o;

   int errors = 0;
   int checks = 0;
   int pops   = 0;
   int pops_mark;

   // Reference model: FIFO of expected {p, g, cin} vectors, at most 2 deep
   logic [2*W:0] mq[$];

   pg_gen_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .g         (g),
      .cin_o     (cin_o)
   );

   always #5 clk = ~clk;

   // Expected vector from arithmetic: g[0] is the carry out of a[0]+b[0]+cin
   function automatic logic [2*W:0] ref_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic cv);
      logic [W-1:0] pv;
      logic [W-1:0] gv;
      int           s0;
      pv = av ^ bv;
      gv = av & bv;
      s0 = int'(av[0]) + int'(bv[0]) + int'(cv);
      gv[0] = (s0 >= 2);
      return {pv, gv, cv};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model update on the active edge: reset clears, pop precedes push
   always @(posedge clk) begin
      int  n;
      bit  acc;
      n   = mq.size();
      acc = in_valid && (n < 2);
      if (rst) begin
         mq.delete();
      end else begin
         if (n != 0 && out_ready) begin
            void'(mq.pop_front());
            pops++;
         end
         if (acc) mq.push_back(ref_vec(a, b, cin));
      end
   end

   // Compare process: DUT against model on every cycle, away from the edge
   always @(negedge clk) begin
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, (!rst && mq.size() < 2)});
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0)
         chk("model_pgc", {15'd0, p, g, cin_o}, {15'd0, mq[0]});
   end

   initial begin
      // 1. Reset with an input offered
      rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0; out_ready = 1'b0;
      step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_p", {24'd0, p}, 32'h00);
      chk("rst_g", {24'd0, g}, 32'h00);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
      step();

      // 2. Basic
      a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_p", {24'd0, p}, 32'h0E);
      chk("basic_g", {24'd0, g}, 32'h01);
      chk("basic_cin_o", {31'd0, cin_o}, 32'd0);
      in_valid = 1'b0;
      step();
      chk("basic_drain_valid", {31'd0, out_valid}, 32'd0);

      // 3. Carry fold
      a = 8'h01; b = 8'h00; cin = 1'b1; in_valid = 1'b1;
      step();
      chk("fold1_p", {24'd0, p}, 32'h01);
      chk("fold1_g", {24'd0, g}, 32'h01);
      chk("fold1_cin_o", {31'd0, cin_o}, 32'd1);
      a = 8'h00; b = 8'h00; cin = 1'b1;
      step();
      chk("fold2_p", {24'd0, p}, 32'h00);
      chk("fold2_g", {24'd0, g}, 32'h00);
      a = 8'h81; b = 8'h81; cin = 1'b0;
      step();
      chk("fold3_p", {24'd0, p}, 32'h00);
      chk("fold3_g", {24'd0, g}, 32'h81);
      in_valid = 1'b0;
      step();

      // 4. Backpressure: V1=12/34/1, V2=A5/5A/0, V3=FF/01/1
      out_ready = 1'b0;
      a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
      step();
      a = 8'hA5; b = 8'h5A; cin = 1'b0;
      step();
      chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      a = 8'hFF; b = 8'h01; cin = 1'b1;
      step();
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_p", {24'd0, p}, 32'h26);
      chk("bp_hold_g", {24'd0, g}, 32'h10);
      chk("bp_hold_cin_o", {31'd0, cin_o}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_v2_p", {24'd0, p}, 32'hFF);
      chk("bp_v2_g", {24'd0, g}, 32'h00);
      step();
      in_valid = 1'b0;
      chk("bp_v3_p", {24'd0, p}, 32'hFE);
      chk("bp_v3_g", {24'd0, g}, 32'h01);
      chk("bp_v3_cin_o", {31'd0, cin_o}, 32'd1);
      step();
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

      // 5. Streaming 10 random vectors
      pops_mark = pops;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         cin = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         step();
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_end_valid", {31'd0, out_valid}, 32'd0);
      chk("stream_pop_count", pops - pops_mark, 32'd10);

      // 6. Reset while full discards both entries
      out_ready = 1'b0;
      a = 8'h11; b = 8'h22; cin = 1'b1; in_valid = 1'b1;
      step();
      a = 8'h44; b = 8'h88; cin = 1'b0;
      step();
      chk("rf_full_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("rf_rst_in_ready", {31'd0, in_ready}, 32'd0);
      pops_mark = pops;
      step();
      chk("rf_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rf_p", {24'd0, p}, 32'h00);
      chk("rf_g", {24'd0, g}, 32'h00);
      chk("rf_cin_o", {31'd0, cin_o}, 32'd0);
      rst = 1'b0;
      a = 8'h33; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
      step();
      chk("rf_next_p", {24'd0, p}, 32'h3C);
      chk("rf_next_g", {24'd0, g}, 32'h03);
      in_valid = 1'b0;
      step();
      chk("rf_pop_count", pops - pops_mark, 32'd1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pg_gen_stage.md
Name: pg_gen_stage

Overview:
- Registered propagate/generate pre-processing stage at the head of the prefix adder datapath.
- Accepts operand pairs A, B and a carry-in under a valid/ready handshake.
- Produces per-bit P = A^B and G = A&B. The carry-in is folded into bit 0's generate term, so the downstream prefix tree needs no separate carry input.
- Feeds the P/G buffer cells and black/grey cells of the prefix tree. Contains a 2-entry skid buffer so that in_ready is decoupled from out_ready.

Parameters:
WIDTH, 16, operand width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream offers A, B, cin this cycle
in_ready  output  1  stage can accept an input this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  adder carry-in
out_valid  output  1  p, g, cin_o hold a valid vector
out_ready  input  1  downstream prefix tree accepts the vector
p  output  WIDTH  per-bit propagate
g  output  WIDTH  per-bit generate, bit 0 carry-folded
cin_o  output  1  carry-in registered alongside the vector, used for sum bit 0

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high.
- Arithmetic, computed at the input and captured into the registers:
  - for i = 1..WIDTH-1: p[i] = a[i]^b[i], g[i] = a[i]&b[i]
  - p[0] = a[0]^b[0]
  - g[0] = (a[0]&b[0]) | ((a[0]^b[0])&cin)
  - No width growth; carry-out is resolved downstream.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = !rst & (state != FULL). in_ready never depends combinationally on out_ready.
- Storage: main register (drives p, g, cin_o) plus one skid register.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register valid, skid register empty.
  - FULL: both registers valid, in_ready=0.
- Transitions (evaluated each clk edge with rst=0):
  - EMPTY: accept -> ONE, main <= input. Otherwise stay in EMPTY.
  - ONE, accept & pop: stay in ONE, main <= input.
  - ONE, accept & !pop: -> FULL, skid <= input.
  - ONE, !accept & pop: -> EMPTY.
  - ONE, neither: hold.
  - FULL, pop: -> ONE, main <= skid.
  - FULL, no pop: hold.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 when the stage was EMPTY, or when it was ONE and popped that cycle.
- Throughput: 1 vector per cycle while out_ready=1.
- Ordering: strict FIFO order. No drop, no duplication.
- Stability: while out_valid=1 and out_ready=0, p, g and cin_o are held constant.
- Inputs while in_ready=0: ignored, regardless of in_valid.
- Reset:
  - Any cycle with rst=1 sets the state to EMPTY and zeros the main and skid registers.
  - Following edge: out_valid=0, p=0, g=0, cin_o=0.
  - in_ready=0 while rst=1 and returns to 1 in the first cycle with rst=0.
  - Reset mid-operation (ONE or FULL) discards all held vectors. A pop presented in the same cycle as rst does not complete.
- Output reset values: out_valid=0, p=0, g=0, cin_o=0, in_ready=0 during reset and 1 after.

Test Plan:
1. Reset: WIDTH=8, rst=1 for 2 cycles with in_valid=1, a=0xFF -> out_valid=0, p=0x00, g=0x00, in_ready=0. First cycle after rst=0 -> in_ready=1.
2. Basic: a=0x0F, b=0x01, cin=0, out_ready=1 -> next cycle out_valid=1, p=0x0E, g=0x01, cin_o=0. With in_valid=0 the following cycle -> out_valid=0.
3. Carry fold:
   - a=0x01, b=0x00, cin=1 -> p=0x01, g=0x01, cin_o=1.
   - a=0x00, b=0x00, cin=1 -> p=0x00, g=0x00.
   - a=0x81, b=0x81, cin=0 -> p=0x00, g=0x81.
4. Backpressure: out_ready=0, offer V1, V2, V3 on consecutive cycles -> V1 and V2 accepted, in_ready=0 from the cycle after V2's accept, V3 held by the source, p/g show V1 unchanged. Raise out_ready -> V1, V2, V3 emerge in order; in_ready=1 the cycle after V1 pops.
5. Streaming: 10 random vectors, in_valid=1 and out_ready=1 continuously -> out_valid=1 from cycle 2 for 10 consecutive cycles. Each p/g matches the reference formula, with no gaps or duplicates.
6. Reset in FULL: fill both entries with out_ready=0, assert rst for 1 cycle -> out_valid=0 next cycle. Both vectors are never presented. A subsequent vector a=0x33, b=0x0F, cin=0 yields p=0x3C, g=0x03.
